chirp_sequencer: RTL and testbench

- Controller that sequences the chirp DDS core: latches a chirp parameter set, issues one-cycle chirp_init pulses at a programmed pulse-repetition interval (PRI), and counts chirps in a burst.
- Monitors the DDS chirp_ready/chirp_active/chirp_done handshake and reports PRI overruns and hung chirps.
- Sits between the register/control interface and the chirp DDS core in the fmc_tclk (245.76 MHz) domain.

---
 rtl/chirp_seq_pkg.sv | 22 ++
 rtl/chirp_param_latch.sv | 29 ++
 rtl/chirp_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_chirp_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/chirp_seq_pkg.sv
// Shared types and constants for the chirp sequencer: FSM state encoding,
// the DDS chirp parameter record and the minimum PRI.
package chirp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        FIRE   = 3'd2,
        ACTIVE = 3'd3,
        GAP    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [31:0] freq_offset;
        logic [31:0] tuning_coef;
        logic [31:0] count_max;
    } chirp_param_t;

    // Shortest PRI the sequencer will honour; smaller programmed values are raised to this
    localparam int unsigned MIN_PRI = 32'd2;

endpackage

// File: rtl/chirp_param_latch.sv
// Registered capture of the chirp parameter record. The record is taken on
// load and held until the next load so the DDS sees stable values for a
// whole burst regardless of what the register interface does meanwhile.
module chirp_param_latch
    import chirp_seq_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  chirp_param_t d,
    output chirp_param_t q
);

    chirp_param_t q_r;

    // Capture on load, hold otherwise; cleared by reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_r <= '{32'd0, 32'd0, 32'd0};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/chirp_sequencer.sv
// Chirp DDS sequencer: latches a parameter set on start, fires one-cycle
// chirp_init pulses at the programmed PRI, counts chirps in a burst and
// flags PRI overruns and hung chirps (no chirp_done within the timeout).
//
// Counter convention: pri_cnt/to_cnt hold the number of cycles elapsed since
// the FIRE cycle. Thresholds are tested against the incremented value so the
// resulting state change lands exactly on the programmed cycle count, which
// makes consecutive inits pri_cycles+1 apart (ARM costs one cycle).
module chirp_sequencer
    import chirp_seq_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             fmc_tclk,
    input  logic             fmc_tresetn,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      freq_offset_in,
    input  logic [31:0]      tuning_word_coeff_in,
    input  logic [31:0]      chirp_count_max_in,
    input  logic [CNT_W-1:0] pri_cycles_in,
    input  logic [CNT_W-1:0] num_chirps_in,
    input  logic             chirp_ready,
    input  logic             chirp_active,
    input  logic             chirp_done,
    output logic             chirp_init,
    output logic             chirp_enable,
    output logic [31:0]      freq_offset_out,
    output logic [31:0]      tuning_word_coeff_out,
    output logic [31:0]      chirp_count_max_out,
    output logic             busy,
    output logic [CNT_W-1:0] chirp_index,
    output logic             burst_done,
    output logic             pri_overrun,
    output logic             timeout_err
);

    localparam logic [CNT_W-1:0] ONE_W       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_W      = CNT_W'(0);
    localparam logic [CNT_W-1:0] MIN_PRI_W   = CNT_W'(MIN_PRI);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    seq_state_t       state_r, state_next;
    logic [CNT_W-1:0] pri_cycles_r, num_chirps_r, pri_cnt_r, to_cnt_r, chirp_index_r;
    logic             stop_pending_r, overrun_seen_r;
    logic             chirp_init_r, chirp_enable_r, busy_r, burst_done_r;
    logic             pri_overrun_r, timeout_err_r;
    logic             load_s, end_s, overrun_s, timeout_s;
    logic             pri_reach_s, to_reach_s, last_s, stop_req_s;
    chirp_param_t     param_in_s, param_out_s;

    // chirp_active is informational only; sequencing keys on ready/done
    logic unused_s;
    assign unused_s = chirp_active;

    assign pri_reach_s = (pri_cnt_r + ONE_W) >= pri_cycles_r;
    assign to_reach_s  = (to_cnt_r + ONE_W) >= TIMEOUT_LIM;
    assign last_s      = (num_chirps_r != ZERO_W) && (chirp_index_r == num_chirps_r);
    assign stop_req_s  = stop | stop_pending_r;

    assign param_in_s.freq_offset = freq_offset_in;
    assign param_in_s.tuning_coef = tuning_word_coeff_in;
    assign param_in_s.count_max   = chirp_count_max_in;

    chirp_param_latch u_param_latch (
        .clk    (fmc_tclk),
        .resetn (fmc_tresetn),
        .load   (load_s),
        .d      (param_in_s),
        .q      (param_out_s)
    );

    // FSM state register
    always_ff @(posedge fmc_tclk) begin
        if (!fmc_tresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state_r;
        load_s     = 1'b0;
        end_s      = 1'b0;
        overrun_s  = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // stop beats start when both arrive together
                if (start && !stop) begin
                    load_s     = 1'b1;
                    state_next = ARM;
                end else begin
                    state_next = IDLE;
                end
            end
            ARM: begin
                if (stop_req_s) begin
                    end_s      = 1'b1;
                    state_next = IDLE;
                end else if (chirp_ready) begin
                    state_next = FIRE;
                end else begin
                    state_next = ARM;
                end
            end
            FIRE: begin
                state_next = ACTIVE;
            end
            ACTIVE: begin
                if (chirp_done) begin
                    if (stop_req_s || last_s) begin
                        end_s      = 1'b1;
                        state_next = IDLE;
                    end else if (overrun_seen_r || pri_reach_s) begin
                        // PRI already used up: re-arm back-to-back
                        state_next = ARM;
                    end else begin
                        state_next = GAP;
                    end
                end else begin
                    overrun_s = pri_reach_s;
                    if (to_reach_s) begin
                        timeout_s  = 1'b1;
                        end_s      = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = ACTIVE;
                    end
                end
            end
            GAP: begin
                if (stop_req_s) begin
                    end_s      = 1'b1;
                    state_next = IDLE;
                end else if (pri_reach_s) begin
                    state_next = ARM;
                end else begin
                    state_next = GAP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered handshake/status outputs and pending-stop tracking
    always_ff @(posedge fmc_tclk) begin
        if (!fmc_tresetn) begin
            chirp_init_r   <= 1'b0;
            burst_done_r   <= 1'b0;
            busy_r         <= 1'b0;
            chirp_enable_r <= 1'b0;
            stop_pending_r <= 1'b0;
        end else begin
            chirp_init_r <= (state_next == FIRE);
            burst_done_r <= end_s;
            if (load_s) begin
                busy_r         <= 1'b1;
                chirp_enable_r <= 1'b1;
                stop_pending_r <= 1'b0;
            end else if (end_s) begin
                busy_r         <= 1'b0;
                chirp_enable_r <= 1'b0;
                stop_pending_r <= 1'b0;
            end else if (stop && (state_r != IDLE)) begin
                stop_pending_r <= 1'b1;
            end else begin
                stop_pending_r <= stop_pending_r;
            end
        end
    end

    // Burst configuration, chirp index and PRI/timeout counters
    always_ff @(posedge fmc_tclk) begin
        if (!fmc_tresetn) begin
            pri_cycles_r  <= ZERO_W;
            num_chirps_r  <= ZERO_W;
            chirp_index_r <= ZERO_W;
            pri_cnt_r     <= ZERO_W;
            to_cnt_r      <= ZERO_W;
        end else begin
            if (load_s) begin
                pri_cycles_r  <= (pri_cycles_in < MIN_PRI_W) ? MIN_PRI_W : pri_cycles_in;
                num_chirps_r  <= num_chirps_in;
                chirp_index_r <= ZERO_W;
            end else if (state_r == FIRE) begin
                chirp_index_r <= chirp_index_r + ONE_W;
            end
            if (state_r == FIRE) begin
                pri_cnt_r <= ONE_W;
                to_cnt_r  <= ONE_W;
            end else if (state_r == ACTIVE) begin
                pri_cnt_r <= pri_cnt_r + ONE_W;
                if (to_cnt_r < TIMEOUT_LIM) begin
                    to_cnt_r <= to_cnt_r + ONE_W;
                end
            end else if (state_r == GAP) begin
                pri_cnt_r <= pri_cnt_r + ONE_W;
            end
        end
    end

    // Sticky error flags, cleared when a new burst starts
    always_ff @(posedge fmc_tclk) begin
        if (!fmc_tresetn) begin
            pri_overrun_r  <= 1'b0;
            timeout_err_r  <= 1'b0;
            overrun_seen_r <= 1'b0;
        end else begin
            if (load_s) begin
                pri_overrun_r <= 1'b0;
                timeout_err_r <= 1'b0;
            end else begin
                pri_overrun_r <= pri_overrun_r | overrun_s;
                timeout_err_r <= timeout_err_r | timeout_s;
            end
            if (state_r == FIRE) begin
                overrun_seen_r <= 1'b0;
            end else begin
                overrun_seen_r <= overrun_seen_r | overrun_s;
            end
        end
    end

    assign chirp_init            = chirp_init_r;
    assign chirp_enable          = chirp_enable_r;
    assign busy                  = busy_r;
    assign burst_done            = burst_done_r;
    assign chirp_index           = chirp_index_r;
    assign pri_overrun           = pri_overrun_r;
    assign timeout_err           = timeout_err_r;
    assign freq_offset_out       = param_out_s.freq_offset;
    assign tuning_word_coeff_out = param_out_s.tuning_coef;
    assign chirp_count_max_out   = param_out_s.count_max;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Bench for chirp_sequencer: a behavioural DDS answers chirp_init with
// chirp_done after chirp_count_max cycles; expected init/burst_done events
// (cycle, index) are queued by the stimulus and checked by a monitor.
module tb_chirp_sequencer;

    logic        fmc_tclk = 1'b0;
    logic        fmc_tresetn = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [31:0] freq_offset_in = 32'd0, tuning_word_coeff_in = 32'd0, chirp_count_max_in = 32'd0;
    logic [31:0] pri_cycles_in = 32'd0, num_chirps_in = 32'd0;
    logic        chirp_ready = 1'b1, chirp_active = 1'b0, chirp_done = 1'b0;
    logic        chirp_init, chirp_enable, busy, burst_done, pri_overrun, timeout_err;
    logic [31:0] freq_offset_out, tuning_word_coeff_out, chirp_count_max_out, chirp_index;

    chirp_sequencer #(.CNT_W(32), .TIMEOUT_CYCLES(256)) dut (
        .fmc_tclk(fmc_tclk), .fmc_tresetn(fmc_tresetn), .start(start), .stop(stop),
        .freq_offset_in(freq_offset_in), .tuning_word_coeff_in(tuning_word_coeff_in),
        .chirp_count_max_in(chirp_count_max_in), .pri_cycles_in(pri_cycles_in),
        .num_chirps_in(num_chirps_in), .chirp_ready(chirp_ready), .chirp_active(chirp_active),
        .chirp_done(chirp_done), .chirp_init(chirp_init), .chirp_enable(chirp_enable),
        .freq_offset_out(freq_offset_out), .tuning_word_coeff_out(tuning_word_coeff_out),
        .chirp_count_max_out(chirp_count_max_out), .busy(busy), .chirp_index(chirp_index),
        .burst_done(burst_done), .pri_overrun(pri_overrun), .timeout_err(timeout_err)
    );

    always #5 fmc_tclk = ~fmc_tclk;

    int cyc = 0;
    always @(posedge fmc_tclk) cyc <= cyc + 1;

    typedef struct { int cyc; int idx; } ev_t;
    ev_t init_q[$];
    ev_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural DDS: done arrives exactly chirp_count_max cycles after init
    int dds_cnt = 0;
    bit dds_run = 1'b0;
    bit dds_hang = 1'b0;
    always @(negedge fmc_tclk) begin
        chirp_done = 1'b0;
        if (chirp_init) begin
            dds_cnt = int'(chirp_count_max_out);
            dds_run = 1'b1;
            chirp_active = 1'b1;
        end else if (dds_run) begin
            dds_cnt--;
            if (dds_cnt == 0) begin
                dds_run = 1'b0;
                chirp_active = 1'b0;
                chirp_done = !dds_hang;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT pulses init or burst_done
    always @(negedge fmc_tclk) begin
        ev_t e;
        if (chirp_init) begin
            check("init_expected", longint'(init_q.size() > 0), 1);
            if (init_q.size() > 0) begin
                e = init_q.pop_front();
                check("init_cycle", longint'(cyc), longint'(e.cyc));
                check("init_index", longint'(chirp_index), longint'(e.idx));
            end
        end
        if (burst_done) begin
            check("done_expected", longint'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                e = done_q.pop_front();
                check("done_cycle", longint'(cyc), longint'(e.cyc));
                check("done_index", longint'(chirp_index), longint'(e.idx));
            end
        end
    end

    task automatic push_init(input int c, input int idx);
        ev_t e; e.cyc = c; e.idx = idx; init_q.push_back(e);
    endtask

    task automatic push_done(input int c, input int idx);
        ev_t e; e.cyc = c; e.idx = idx; done_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge fmc_tclk);
    endtask

    task automatic start_burst(input int num, input int pri, input int len, output int s);
        @(negedge fmc_tclk);
        freq_offset_in       = 32'h1234_5678;
        tuning_word_coeff_in = 32'h0000_0A0B;
        chirp_count_max_in   = 32'(len);
        pri_cycles_in        = 32'(pri);
        num_chirps_in        = 32'(num);
        start = 1'b1;
        s = cyc;
        @(negedge fmc_tclk);
        start = 1'b0;
    endtask

    task automatic queues_empty(input string name);
        check(name, longint'(init_q.size() + done_q.size()), 0);
    endtask

    int s;

    initial begin
        // Reset state
        repeat (3) @(negedge fmc_tclk);
        fmc_tresetn = 1'b1;
        check("rst_busy", longint'(busy), 0);
        check("rst_enable", longint'(chirp_enable), 0);
        check("rst_index", longint'(chirp_index), 0);
        check("rst_flags", longint'({pri_overrun, timeout_err, burst_done, chirp_init}), 0);

        // Burst timing: 4 chirps, PRI 100, length 20
        start_burst(4, 100, 20, s);
        push_init(s + 2, 0); push_init(s + 103, 1); push_init(s + 204, 2); push_init(s + 305, 3);
        push_done(s + 326, 4);
        wait_until(s + 3);
        check("b1_freq", longint'(freq_offset_out), 64'h1234_5678);
        check("b1_tw", longint'(tuning_word_coeff_out), 64'h0A0B);
        check("b1_cmax", longint'(chirp_count_max_out), 20);
        check("b1_busy", longint'(busy), 1);
        check("b1_enable", longint'(chirp_enable), 1);
        wait_until(s + 340);
        check("b1_overrun", longint'(pri_overrun), 0);
        check("b1_busy_end", longint'(busy), 0);
        check("b1_enable_end", longint'(chirp_enable), 0);
        queues_empty("b1_events");

        // PRI overrun: PRI 10 with 50-cycle chirps, back-to-back re-arm
        start_burst(3, 10, 50, s);
        push_init(s + 2, 0); push_init(s + 54, 1); push_init(s + 106, 2);
        push_done(s + 157, 3);
        wait_until(s + 11);
        check("ov_not_yet", longint'(pri_overrun), 0);
        wait_until(s + 12);
        check("ov_set", longint'(pri_overrun), 1);
        wait_until(s + 170);
        check("ov_sticky", longint'(pri_overrun), 1);
        queues_empty("ov_events");

        // Continuous mode, stop during the 3rd chirp
        start_burst(0, 64, 20, s);
        push_init(s + 2, 0); push_init(s + 67, 1); push_init(s + 132, 2);
        push_done(s + 153, 3);
        wait_until(s + 2);
        check("cont_ov_cleared", longint'(pri_overrun), 0);
        wait_until(s + 140);
        stop = 1'b1;
        @(negedge fmc_tclk);
        stop = 1'b0;
        wait_until(s + 152);
        check("cont_busy_before", longint'(busy), 1);
        wait_until(s + 153);
        check("cont_busy_after", longint'(busy), 0);
        wait_until(s + 220);
        queues_empty("cont_events");

        // Timeout: DDS never reports done
        dds_hang = 1'b1;
        start_burst(2, 100, 20, s);
        push_init(s + 2, 0);
        push_done(s + 258, 1);
        wait_until(s + 257);
        check("to_not_yet", longint'(timeout_err), 0);
        check("to_busy", longint'(busy), 1);
        wait_until(s + 258);
        check("to_err", longint'(timeout_err), 1);
        check("to_enable", longint'(chirp_enable), 0);
        check("to_busy_end", longint'(busy), 0);
        wait_until(s + 270);
        dds_hang = 1'b0;
        queues_empty("to_events");

        // Ready gating and parameter hold
        chirp_ready = 1'b0;
        start_burst(1, 100, 20, s);
        freq_offset_in       = 32'hDEAD_BEEF;
        tuning_word_coeff_in = 32'h5555_AAAA;
        chirp_count_max_in   = 32'd999;
        check("rg_to_cleared", longint'(timeout_err), 0);
        push_init(s + 32, 0);
        push_done(s + 53, 1);
        wait_until(s + 31);
        chirp_ready = 1'b1;
        wait_until(s + 40);
        check("rg_freq", longint'(freq_offset_out), 64'h1234_5678);
        check("rg_tw", longint'(tuning_word_coeff_out), 64'h0A0B);
        check("rg_cmax", longint'(chirp_count_max_out), 20);
        wait_until(s + 60);
        queues_empty("rg_events");

        // Reset in the middle of a burst
        start_burst(4, 100, 20, s);
        push_init(s + 2, 0);
        wait_until(s + 30);
        fmc_tresetn = 1'b0;
        @(negedge fmc_tclk);
        fmc_tresetn = 1'b1;
        check("mr_busy", longint'(busy), 0);
        check("mr_enable", longint'(chirp_enable), 0);
        check("mr_index", longint'(chirp_index), 0);
        check("mr_params", longint'(freq_offset_out | tuning_word_coeff_out | chirp_count_max_out), 0);
        check("mr_flags", longint'({pri_overrun, timeout_err, burst_done, chirp_init}), 0);
        wait_until(s + 250);
        check("mr_busy_later", longint'(busy), 0);
        queues_empty("mr_events");

        // start and stop together while idle
        @(negedge fmc_tclk);
        start = 1'b1; stop = 1'b1;
        @(negedge fmc_tclk);
        start = 1'b0; stop = 1'b0;
        check("col_busy", longint'(busy), 0);
        check("col_enable", longint'(chirp_enable), 0);
        repeat (10) @(negedge fmc_tclk);
        check("col_busy_later", longint'(busy), 0);
        queues_empty("col_events");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
